// File: rtl/mp_frame_memory.sv
// rtl/mp_frame_memory.sv - multi-port data memory with framebuffer scan-out
module mp_frame_memory #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 11,
  parameter int NUM_RD    = 3,
  parameter int FORWARD   = 0,
  parameter int FB_BASE   = 1792,
  parameter int FB_PIXELS = 256,
  parameter int PIX_W     = 24
) (
  input  logic                       i_clk,
  input  logic                       i_reset,
  output logic                       o_init_done,
  input  logic [1:0]                 i_wr_en,
  input  logic [2*ADDR_W-1:0]        i_wr_addr,
  input  logic [2*DATA_W-1:0]        i_wr_data,
  output logic [1:0]                 o_wr_valid,
  input  logic [NUM_RD-1:0]          i_rd_en,
  input  logic [NUM_RD*ADDR_W-1:0]   i_rd_addr,
  output logic [NUM_RD*DATA_W-1:0]   o_rd_data,
  output logic [NUM_RD-1:0]          o_rd_valid,
  input  logic                       i_scan_en,
  input  logic                       i_pix_ready,
  output logic                       o_pix_valid,
  output logic [PIX_W-1:0]           o_pix_data,
  output logic                       o_pix_first,
  output logic                       o_pix_last
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] CLR_LAST  = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] FB_LAST   = ADDR_W'(FB_PIXELS - 1);
  localparam logic [ADDR_W-1:0] FB_BASE_A = ADDR_W'(FB_BASE);

  typedef enum logic {MS_INIT, MS_RUN} main_state_t;
  typedef enum logic [1:0] {SC_IDLE, SC_FETCH, SC_HOLD} scan_state_t;

  logic [DATA_W-1:0] r_mem [DEPTH];

  main_state_t r_main_state, w_main_next;
  logic [ADDR_W-1:0] r_clr_ptr;
  logic              r_init_done;
  logic              w_run;

  logic [ADDR_W-1:0] w_wa0, w_wa1;
  logic [DATA_W-1:0] w_wd0, w_wd1;
  logic              w_same_addr;
  logic [1:0]        r_wr_valid;

  logic [DATA_W-1:0]        w_rd_word [NUM_RD];
  logic [NUM_RD*DATA_W-1:0] r_rd_data;
  logic [NUM_RD-1:0]        r_rd_valid;

  scan_state_t       r_scan_state, w_scan_next;
  logic [ADDR_W-1:0] r_pix_ptr;
  logic [ADDR_W-1:0] w_fb_addr;
  logic [PIX_W-1:0]  w_fb_pix;
  logic              r_pix_valid, r_pix_first, r_pix_last;
  logic [PIX_W-1:0]  r_pix_data;

  assign w_wa0       = i_wr_addr[0 +: ADDR_W];
  assign w_wa1       = i_wr_addr[ADDR_W +: ADDR_W];
  assign w_wd0       = i_wr_data[0 +: DATA_W];
  assign w_wd1       = i_wr_data[DATA_W +: DATA_W];
  assign w_same_addr = (&i_wr_en) && (w_wa0 == w_wa1);
  assign w_run       = (r_main_state == MS_RUN);
  assign w_fb_addr   = FB_BASE_A + r_pix_ptr;
  assign w_fb_pix    = r_mem[w_fb_addr][PIX_W-1:0];

  assign o_init_done = r_init_done;
  assign o_wr_valid  = r_wr_valid;
  assign o_rd_data   = r_rd_data;
  assign o_rd_valid  = r_rd_valid;
  assign o_pix_valid = r_pix_valid;
  assign o_pix_data  = r_pix_data;
  assign o_pix_first = r_pix_first;
  assign o_pix_last  = r_pix_last;

  // Main FSM next state: leave INIT once the last word has been cleared.
  always_comb begin
    w_main_next = r_main_state;
    if (r_main_state == MS_INIT && r_clr_ptr == CLR_LAST) w_main_next = MS_RUN;
  end

  // Main FSM state, clear pointer and init_done flag.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_main_state <= MS_INIT;
      r_clr_ptr    <= '0;
      r_init_done  <= 1'b0;
    end else begin
      r_main_state <= w_main_next;
      if (r_main_state == MS_INIT) r_clr_ptr <= r_clr_ptr + 1'b1;
      r_init_done  <= (w_main_next == MS_RUN);
    end
  end

  // Storage: the clear sweep owns the array during INIT; port 1 is applied last so it wins collisions.
  always_ff @(posedge i_clk) begin
    if (r_main_state == MS_INIT) begin
      r_mem[r_clr_ptr] <= '0;
    end else begin
      if (i_wr_en[0]) r_mem[w_wa0] <= w_wd0;
      if (i_wr_en[1]) r_mem[w_wa1] <= w_wd1;
    end
  end

  // Write acknowledge; port 0 reports a drop when port 1 overrides it.
  always_ff @(posedge i_clk) begin
    if (i_reset || !w_run) r_wr_valid <= 2'b00;
    else                   r_wr_valid <= {i_wr_en[1], i_wr_en[0] & ~w_same_addr};
  end

  // Read word selection, optionally bypassing the same-cycle winning write.
  always_comb begin
    for (int k = 0; k < NUM_RD; k++) begin
      w_rd_word[k] = r_mem[i_rd_addr[k*ADDR_W +: ADDR_W]];
      if (FORWARD != 0) begin
        if (i_wr_en[0] && i_rd_addr[k*ADDR_W +: ADDR_W] == w_wa0) w_rd_word[k] = w_wd0;
        if (i_wr_en[1] && i_rd_addr[k*ADDR_W +: ADDR_W] == w_wa1) w_rd_word[k] = w_wd1;
      end
    end
  end

  // Registered read ports; data holds while a port is idle.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_rd_data  <= '0;
      r_rd_valid <= '0;
    end else if (!w_run) begin
      r_rd_valid <= '0;
    end else begin
      r_rd_valid <= i_rd_en;
      for (int k = 0; k < NUM_RD; k++)
        if (i_rd_en[k]) r_rd_data[k*DATA_W +: DATA_W] <= w_rd_word[k];
    end
  end

  // Scanner next state: fetch, hold until accepted, continue or park.
  always_comb begin
    w_scan_next = r_scan_state;
    case (r_scan_state)
      SC_IDLE:  if (r_init_done && i_scan_en) w_scan_next = SC_FETCH;
      SC_FETCH: w_scan_next = SC_HOLD;
      SC_HOLD:  if (i_pix_ready) w_scan_next = i_scan_en ? SC_FETCH : SC_IDLE;
      default:  w_scan_next = SC_IDLE;
    endcase
  end

  // Scanner state, pixel pointer and the offered pixel registers.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_scan_state <= SC_IDLE;
      r_pix_ptr    <= '0;
      r_pix_valid  <= 1'b0;
      r_pix_data   <= '0;
      r_pix_first  <= 1'b0;
      r_pix_last   <= 1'b0;
    end else begin
      r_scan_state <= w_scan_next;
      case (r_scan_state)
        SC_FETCH: begin
          r_pix_valid <= 1'b1;
          r_pix_data  <= w_fb_pix;
          r_pix_first <= (r_pix_ptr == '0);
          r_pix_last  <= (r_pix_ptr == FB_LAST);
        end
        SC_HOLD: begin
          if (i_pix_ready) begin
            r_pix_valid <= 1'b0;
            r_pix_first <= 1'b0;
            r_pix_last  <= 1'b0;
            if (!i_scan_en || r_pix_ptr == FB_LAST) r_pix_ptr <= '0;
            else                                    r_pix_ptr <= r_pix_ptr + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
